wb_multi_master_port: RTL

//  Parametrised bridge from N CPU-side memory request channels (icache, dcache, ...)

---
 rtl/wb_multi_master_port_pkg.sv | 13 +
 rtl/wb_multi_master_port_rr_arbiter.sv | 31 +++
 rtl/wb_multi_master_port.sv | 139 +++++++++++++
 3 files changed

// File: rtl/wb_multi_master_port_pkg.sv
// rtl/wb_multi_master_port_pkg.sv - shared line geometry and wishbone port state type
package lc3b_types;

    localparam int LINE_OFFSET_W = 4;
    localparam int LINE_W        = 128;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } wb_state_t;

endpackage

// File: rtl/wb_multi_master_port_rr_arbiter.sv
// rtl/wb_multi_master_port_rr_arbiter.sv - combinational round-robin arbiter
module rr_arbiter #(
    parameter int N     = 2,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     grant_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    logic [IDX_W-1:0] k;

    // Walk the channels starting at the pointer; the first requester found wins.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        k       = '0;
        for (int off = 0; off < N; off++) begin
            k = IDX_W'((int'(ptr_i) + off) % N);
            if (!any_o && req_i[k]) begin
                grant_o[k] = 1'b1;
                idx_o      = k;
                any_o      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_multi_master_port.sv
// rtl/wb_multi_master_port.sv - N-channel line request bridge onto one registered wishbone master
module wb_multi_master_port
    import lc3b_types::*;
#(
    parameter int NUM_CH      = 2,
    parameter int ADDR_W      = 16,
    parameter int OFFSET_W    = LINE_OFFSET_W,
    parameter int DATA_W      = LINE_W,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_CH-1:0]            ch_read,
    input  logic [NUM_CH-1:0]            ch_write,
    input  logic [NUM_CH*ADDR_W-1:0]     ch_addr,
    input  logic [NUM_CH*DATA_W-1:0]     ch_wdata,
    input  logic [NUM_CH*(DATA_W/8)-1:0] ch_byte_en,
    output logic [NUM_CH-1:0]            ch_resp,
    output logic [NUM_CH-1:0]            ch_err,
    output logic [DATA_W-1:0]            ch_rdata,
    output logic [ADDR_W-OFFSET_W-1:0]   wb_ADR,
    output logic [DATA_W-1:0]            wb_DAT_S,
    output logic [DATA_W/8-1:0]          wb_SEL,
    output logic                         wb_STB,
    output logic                         wb_CYC,
    output logic                         wb_WE,
    input  logic [DATA_W-1:0]            wb_DAT_M,
    input  logic                         wb_ACK
);

    localparam int SEL_W    = DATA_W / 8;
    localparam int WB_ADR_W = ADDR_W - OFFSET_W;
    localparam int IDX_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int TMR_W    = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [TMR_W:0] TMO = (TMR_W + 1)'(TIMEOUT_CYC);

    wb_state_t             state_q;
    logic                  stb_q;
    logic                  we_q;
    logic [WB_ADR_W-1:0]   adr_q;
    logic [DATA_W-1:0]     dat_q;
    logic [SEL_W-1:0]      sel_q;
    logic [NUM_CH-1:0]     gnt_q;
    logic [IDX_W-1:0]      gidx_q;
    logic [IDX_W-1:0]      ptr_q;
    logic [TMR_W-1:0]      timer_q;
    logic [NUM_CH-1:0]     resp_q;
    logic [NUM_CH-1:0]     err_q;
    logic [DATA_W-1:0]     rdata_q;

    logic [NUM_CH-1:0]     arb_grant;
    logic [IDX_W-1:0]      arb_idx;
    logic                  arb_any;

    rr_arbiter #(
        .N     (NUM_CH),
        .IDX_W (IDX_W)
    ) u_arb (
        .req_i   (ch_read | ch_write),
        .ptr_i   (ptr_q),
        .grant_o (arb_grant),
        .idx_o   (arb_idx),
        .any_o   (arb_any)
    );

    // Transaction FSM: capture the granted request, hold the bus until ACK or timeout, pulse the response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
            gnt_q   <= '0;
            gidx_q  <= '0;
            ptr_q   <= '0;
            timer_q <= '0;
            resp_q  <= '0;
            err_q   <= '0;
            rdata_q <= '0;
        end else begin
            resp_q <= '0;
            err_q  <= '0;
            case (state_q)
                IDLE: begin
                    if (arb_any) begin
                        // A channel asserting both read and write is treated as a write.
                        we_q    <= ch_write[arb_idx];
                        adr_q   <= ch_addr[arb_idx*ADDR_W + OFFSET_W +: WB_ADR_W];
                        dat_q   <= ch_wdata[arb_idx*DATA_W +: DATA_W];
                        sel_q   <= ch_write[arb_idx] ? ch_byte_en[arb_idx*SEL_W +: SEL_W] : '1;
                        gnt_q   <= arb_grant;
                        gidx_q  <= arb_idx;
                        timer_q <= '0;
                        stb_q   <= 1'b1;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    if (wb_ACK) begin
                        stb_q   <= 1'b0;
                        rdata_q <= we_q ? '0 : wb_DAT_M;
                        resp_q  <= gnt_q;
                        state_q <= RESP;
                    end else if (TIMEOUT_CYC != 0 && ({1'b0, timer_q} + 1'b1) == TMO) begin
                        // The TIMEOUT_CYC-th BUSY cycle passed without ACK: abort with error.
                        stb_q   <= 1'b0;
                        rdata_q <= '0;
                        resp_q  <= gnt_q;
                        err_q   <= gnt_q;
                        state_q <= RESP;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                RESP: begin
                    ptr_q   <= (int'(gidx_q) == NUM_CH - 1) ? '0 : gidx_q + 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    stb_q   <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign wb_STB   = stb_q;
    assign wb_CYC   = stb_q;
    assign wb_WE    = we_q;
    assign wb_ADR   = adr_q;
    assign wb_DAT_S = dat_q;
    assign wb_SEL   = sel_q;
    assign ch_resp  = resp_q;
    assign ch_err   = err_q;
    assign ch_rdata = rdata_q;

endmodule
